// File: rtl/led_stretch_pwm.sv
// LED output stage: registers the core's LED pattern, stretches short pulses so
// they stay visible, gates the result with a period-aligned PWM brightness.
module led_stretch_pwm #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int PWM_BITS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    led_in,
  input  logic [PWM_BITS-1:0] duty,
  output logic [WIDTH-1:0]    led_stretched,
  output logic [WIDTH-1:0]    led_out,
  output logic [15:0]         change_cnt
);

  localparam int                 HOLD_W    = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [PWM_BITS-1:0] DUTY_FULL = '1;
  localparam logic [15:0]        CNT_MAX   = 16'hFFFF;

  logic [WIDTH-1:0]    led_q;
  logic [WIDTH-1:0]    led_q_prev;
  logic [HOLD_W-1:0]   hold_cnt [WIDTH];
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_q;

  logic pwm_wrap;
  logic pwm_en;
  logic led_changed;

  assign pwm_wrap    = (pwm_cnt == DUTY_FULL);
  // Full-scale duty must be steady on; a plain compare would leave one dark slot.
  assign pwm_en      = (duty_q == DUTY_FULL) || (pwm_cnt < duty_q);
  assign led_changed = (led_q != led_q_prev);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q      <= '0;
      led_q_prev <= '0;
    end else begin
      led_q      <= led_in;
      led_q_prev <= led_q;
    end
  end

  // NOTE: the hold counter array is reset explicitly, element by element, so a
  // reset in the middle of a stretch leaves no residual lit lamp afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) hold_cnt[i] <= '0;
      led_stretched <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        // A new pulse reloads the counter even mid-stretch, so no gap appears.
        if (led_q[i])
          hold_cnt[i] <= HOLD_LOAD;
        else if (hold_cnt[i] != '0)
          hold_cnt[i] <= hold_cnt[i] - 1'b1;
        led_stretched[i] <= led_q[i] | (hold_cnt[i] != '0);
      end
    end
  end

  // Duty is captured only at the period boundary so a period is never split.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
      led_out <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_wrap)
        duty_q <= duty;
      led_out <= led_stretched & {WIDTH{pwm_en}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      change_cnt <= '0;
    else if (led_changed && (change_cnt != CNT_MAX))
      change_cnt <= change_cnt + 16'd1;
  end

endmodule

// File: tb/tb_led_stretch_pwm.sv
// Self-checking bench for led_stretch_pwm: directed scenarios plus random
// traffic, compared every cycle against a history-based reference model.
module tb_led_stretch_pwm;

  localparam int HOLD = 16;
  localparam int HMAX = 1 << 17;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [3:0] duty = 4'h0;
  logic [7:0] led_stretched;
  logic [7:0] led_out;
  logic [15:0] change_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference history: input values sampled at each edge since reset release.
  logic [7:0] lin [HMAX];
  logic [3:0] dut [HMAX];
  int         n = 0;
  logic [15:0] chg_model = '0;

  led_stretch_pwm #(.WIDTH(8), .HOLD_CYCLES(HOLD), .PWM_BITS(4)) dut_i (
    .clk(clk), .rst_n(rst_n), .led_in(led_in), .duty(duty),
    .led_stretched(led_stretched), .led_out(led_out), .change_cnt(change_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, n, $time);
    end
  endtask

  function automatic logic [7:0] lin_at(int k);
    return (k < 1) ? 8'h00 : lin[k];
  endfunction

  // Stretched output after edge k: OR of the last HOLD+1 samples, one edge late.
  function automatic logic [7:0] m_stretched(int k);
    logic [7:0] acc = 8'h00;
    if (k < 1) return 8'h00;
    for (int j = k - 1 - HOLD; j <= k - 1; j++) acc |= lin_at(j);
    return acc;
  endfunction

  // Brightness in force after edge k: duty sampled at the latest period start.
  function automatic logic [3:0] m_duty(int k);
    if (k < 16) return 4'h0;
    return dut[k - (k % 16)];
  endfunction

  function automatic logic [7:0] m_out(int k);
    int  p;
    logic [3:0] d;
    logic en;
    if (k < 1) return 8'h00;
    p  = (k - 1) % 16;
    d  = m_duty(k - 1);
    en = (d == 4'hF) || (p < int'(d));
    return en ? m_stretched(k - 1) : 8'h00;
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_stretched"}, 32'(led_stretched), 32'(m_stretched(n)));
    check({tag, "_out"},       32'(led_out),       32'(m_out(n)));
    check({tag, "_cnt"},       32'(change_cnt),    32'(chg_model));
  endtask

  task automatic step(input logic [7:0] li, input logic [3:0] du, input bit chk, input string tag);
    led_in = li;
    duty   = du;
    @(posedge clk);
    n++;
    lin[n] = li;
    dut[n] = du;
    if ((lin_at(n - 1) != lin_at(n - 2)) && (chg_model != 16'hFFFF)) chg_model++;
    #1;
    if (chk) check_all(tag);
  endtask

  task automatic release_reset();
    rst_n     = 1'b1;
    n         = 0;
    chg_model = '0;
  endtask

  int on_cnt;
  int s3_cnt;
  int o3_cnt;

  initial begin
    // T1: outputs stay zero throughout reset even with everything driven high.
    led_in = 8'hFF;
    duty   = 4'hF;
    #1;
    check("t1_rst_out", 32'(led_out), 32'h0);
    check("t1_rst_cnt", 32'(change_cnt), 32'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t1_rst_out", 32'(led_out), 32'h0);
      check("t1_rst_str", 32'(led_stretched), 32'h0);
      check("t1_rst_cnt", 32'(change_cnt), 32'h0);
    end
    release_reset();
    for (int i = 0; i < 40; i++) begin
      step(8'hFF, 4'hF, 1'b1, "t1");
      if (n == 16) check("t1_dark_before_wrap", 32'(led_out), 32'h00);
      if (n == 17) check("t1_on_after_wrap", 32'(led_out), 32'hFF);
    end

    // T2: single-cycle pulse on bit 3 with full brightness.
    for (int i = 0; i < 20; i++) step(8'h00, 4'hF, 1'b1, "t2_idle");
    s3_cnt = 0;
    o3_cnt = 0;
    step(8'h08, 4'hF, 1'b1, "t2");
    for (int i = 0; i < 25; i++) begin
      step(8'h00, 4'hF, 1'b1, "t2");
      if (led_stretched[3]) s3_cnt++;
      if (led_out[3]) o3_cnt++;
      check("t2_other_bits", 32'(led_out & 8'hF7), 32'h0);
    end
    check("t2_stretch_len", 32'(s3_cnt), 32'd17);
    check("t2_out_len", 32'(o3_cnt), 32'd17);

    // T3: steady pattern, duty 4 -> 4 lit cycles per 16.
    for (int i = 0; i < 3; i++) step(8'hFF, 4'h4, 1'b1, "t3_warm");
    for (int i = 0; i < 16 && (n % 16) != 0; i++) step(8'hFF, 4'h4, 1'b1, "t3_align");
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 4'h4, 1'b1, "t3");
      if (led_out == 8'hFF) on_cnt++;
    end
    check("t3_on_cycles", 32'(on_cnt), 32'd4);

    // T4: duty raised to 8 mid-period; only the following period changes.
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, ((n % 16) >= 6) ? 4'h8 : 4'h4, 1'b1, "t4");
      if (led_out == 8'hFF) on_cnt++;
    end
    check("t4_period_kept", 32'(on_cnt), 32'd4);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step(8'hFF, 4'h8, 1'b1, "t4");
      if (led_out == 8'hFF) on_cnt++;
    end
    check("t4_next_period", 32'(on_cnt), 32'd8);

    // Random traffic: sparse pulses, occasional duty changes.
    for (int i = 0; i < 800; i++) begin
      logic [7:0] li;
      li = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 40) == 0) duty = 4'($urandom);
      step(li, duty, 1'b1, "rnd");
    end

    // T5: toggle bit 0 every cycle until the change counter saturates.
    for (int i = 0; i < 70000; i++) begin
      step((i % 2 == 0) ? 8'h01 : 8'h00, 4'hF, 1'b1, "t5");
      if (i > 2 && !led_stretched[0]) check("t5_bit0_steady", 32'(led_stretched[0]), 32'd1);
    end
    check("t5_saturated", 32'(change_cnt), 32'hFFFF);

    // T6: reset while bit 5 is mid-stretch (hold counter at 9).
    for (int i = 0; i < 20; i++) step(8'h00, 4'hF, 1'b1, "t6_idle");
    step(8'h20, 4'hF, 1'b1, "t6");
    for (int i = 0; i < 8; i++) step(8'h00, 4'hF, 1'b1, "t6");
    check("t6_lit_before_rst", 32'(led_stretched[5]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_str", 32'(led_stretched), 32'h0);
    check("t6_rst_out", 32'(led_out), 32'h0);
    check("t6_rst_cnt", 32'(change_cnt), 32'h0);
    @(posedge clk);
    #1;
    release_reset();
    for (int i = 0; i < 30; i++) begin
      step(8'h00, 4'hF, 1'b1, "t6_after");
      check("t6_no_residue", 32'(led_stretched), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
